// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the CPU memory port.
// Request ops, responder FSM states and word width.
package cpu_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_READ  = 2'b00,
    MEM_WRITE = 2'b01,
    MEM_SWAP  = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word store: byte-enabled synchronous write,
// combinational read.
module mem_word_array
  import cpu_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, fixed
// latency, held response, byte-enabled store with swap.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              commit;
  logic              accept;

  mem_op_e           op_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [3:0]        be_q;

  logic              err;
  logic              need_align;
  logic              is_wr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign req_ready = reset_n && (state_q == ST_IDLE);
  assign accept    = req_ready && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = reset_n;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Full-word and read accesses must be aligned; partial
  // byte enables carry the byte offset themselves.
  assign need_align = (op_q == MEM_READ) || (be_q == 4'hF);
  assign is_wr      = (op_q == MEM_WRITE) || (op_q == MEM_SWAP);
  assign err        = (op_q == MEM_RSVD)
                   || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS))
                   || ((addr_q[1:0] != 2'b00) && need_align);
  assign mem_we     = commit && !err && is_wr;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        if (!err && (op_q == MEM_READ || op_q == MEM_SWAP))
          rsp_rdata <= mem_rdata;
        else
          rsp_rdata <= '0;
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      op_q    <= mem_op_e'(req_op);
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_store (
    .clock (clock),
    .we    (mem_we),
    .be    (be_q),
    .idx   (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule
